slave_bus_arbiter: RTL and testbench
====================================

// Module: slave_bus_arbiter
// PURPOSE
//  Two-master arbiter/sequencer for the slave bus: shares one slave_bus_if
//  (ic side) between master 0 (CPU) and master 1 (DMA) with round-robin
//  priority. Latches the granted master's request, issues the bstart pulse,
//  holds ss, waits for bdone, and returns rdata/berror to that master.
// PARAMETERS
//  TIMEOUT_CYCLES  256  WAIT cycles without bdone before an error abort (ARB_TIMEOUT_EN only)
// PORTS
//  bclk        in   1       bus clock; all logic on rising edge
//  brst        in   1       synchronous, active-high reset
//  mN_req      in   1       N=0,1: transfer request, held until mN_done
//  mN_addr     in   32      N=0,1: transfer address
//  mN_wdata    in   32      N=0,1: write data
//  mN_tsize    in   tsize_e N=0,1: transfer size
//  mN_ttype    in   ttype_e N=0,1: transfer type (read/write)
//  mN_gnt      out  1       N=0,1: master N owns the bus (START..RESP)
//  mN_done     out  1       N=0,1: one-cycle completion pulse
//  mN_rdata    out  32      N=0,1: read data; valid while mN_done=1
//  mN_berror   out  1       N=0,1: error flag; valid while mN_done=1
//  ic.*        ic   -       slave_bus_if ic modport (wdata, addr, bstart, tsize, ttype, ss out; rdata, berror, bdone in)
// BEHAVIOUR
//  - Reset (brst=1 at an edge): state=IDLE; all outputs 0; ic.tsize/ttype = enum value 0;
//    last-served pointer = m1, so m0 wins the first contention. Reset mid-transfer
//    drops ss/gnt at the next edge. No done pulse is issued.
//  - All outputs are registered.
//  - FSM states: IDLE, START, WAIT, RESP.
//  - IDLE: when any req is sampled high, select a winner (one requester -> that master;
//    both -> the master != last-served). Latch the winner's addr/wdata/tsize/ttype onto
//    ic.*. Go to START. Latency: req sampled at edge k -> bstart=1 in cycle k+1.
//  - START (1 cycle): bstart=1, ss=1, winner's gnt=1. A bdone sampled at the end of
//    START is accepted; go to RESP. Otherwise go to WAIT.
//  - WAIT: ss=1, bstart=0, gnt held. On bdone, capture ic.rdata and ic.berror, then go
//    to RESP. ic.* request fields stay stable from START through WAIT.
//  - RESP (1 cycle): ss=0; winner's done=1 with captured rdata/berror; gnt still 1;
//    last-served pointer <= winner. Go to IDLE.
//  - Inter-transfer gap: a master that sees done drops req in the following cycle. IDLE
//    samples req at the end of the cycle after RESP. A req still high at that point is
//    treated as a new transfer.
//  - Back-to-back issue: minimum 4 cycles per transfer (START, RESP, IDLE, + >=0 WAIT).
//    Bus turnaround between masters adds no extra cycle.
//  - bdone/berror/rdata sampled in IDLE or RESP are ignored.
//  - Non-granted master outputs stay 0. mN_rdata is 0 outside done.
//  - A request arriving while the bus is busy waits; it is never dropped. Round-robin
//    guarantees it is served within one transfer.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and
//      increments each WAIT cycle.
//    - When the count reaches TIMEOUT_CYCLES with no bdone: go to RESP with berror=1
//      and rdata=0; ss drops.
//    - bdone in the same cycle as the timeout wins: normal completion.
//  - ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until bdone or reset.
// TESTING
//  - Single m0 read, slave bdone 2 cycles after bstart, rdata=32'hDEADBEEF
//    -> bstart 1 cycle, ss 3 cycles, m0_done=1 with m0_rdata=DEADBEEF, m1_* all 0.
//  - m0 and m1 req in the same cycle after reset
//    -> m0 served first, then m1. Repeat the contention -> m0 then m1 again (pointer alternates).
//  - Zero-wait slave (bdone during the START cycle) -> RESP in the next cycle;
//    4-cycle transfer period with m0 streaming.
//  - Slave returns berror=1 on an m1 write to addr 32'h4000_0010
//    -> m1_done=1, m1_berror=1; the next transfer has berror=0.
//  - ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds
//    -> m0_done with berror=1 and rdata=0 after 8 WAIT cycles; m1 pending is then granted.
//  - brst asserted in WAIT of an m1 transfer
//    -> ss/gnt 0 next cycle, no done pulse; the next contention grants m0 first.

Source files
------------

// File: rtl/slave_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// slave_bus_pkg / slave_bus_if
//   Shared types and the slave-bus interface used by slave_bus_arbiter.
//   Modport ic  : interconnect side (drives the request, samples the response).
//   Modport slv : slave side (samples the request, drives the response).
//   Signals     : addr/wdata/tsize/ttype/bstart/ss (request), rdata/berror/bdone
//                 (response).
// -----------------------------------------------------------------------------
package slave_bus_pkg;
    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'd0,
        TSIZE_HALF = 2'd1,
        TSIZE_WORD = 2'd2
    } tsize_e;

    typedef enum logic {
        TTYPE_READ  = 1'b0,
        TTYPE_WRITE = 1'b1
    } ttype_e;

    // One master's request as latched onto the bus
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        tsize_e      tsize;
        ttype_e      ttype;
    } mreq_t;
endpackage

interface slave_bus_if;
    import slave_bus_pkg::*;

    logic [31:0] addr;
    logic [31:0] wdata;
    tsize_e      tsize;
    ttype_e      ttype;
    logic        bstart;
    logic        ss;
    logic [31:0] rdata;
    logic        berror;
    logic        bdone;

    modport ic  (output addr, wdata, tsize, ttype, bstart, ss,
                 input  rdata, berror, bdone);
    modport slv (input  addr, wdata, tsize, ttype, bstart, ss,
                 output rdata, berror, bdone);
endinterface

// File: rtl/slave_bus_arbiter.sv
// -----------------------------------------------------------------------------
// slave_bus_arbiter
//   Shares one slave bus between master 0 (CPU) and master 1 (DMA) with
//   round-robin priority. The winner's request is latched onto the bus, bstart
//   pulses for one cycle, ss is held until bdone, and rdata/berror are handed
//   back to the winner with a one-cycle done pulse.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a WAIT phase lasting TIMEOUT_CYCLES cycles without bdone is
//     aborted and completed with berror=1, rdata=0.
//
//   Ports
//     bclk, brst                   clock, synchronous active-high reset
//     mN_req/addr/wdata/tsize/ttype  request from master N (N=0,1)
//     mN_gnt                       master N owns the bus (START..RESP)
//     mN_done/rdata/berror         completion pulse and response for master N
//     ic                           slave_bus_if.ic modport toward the slave
// -----------------------------------------------------------------------------
module slave_bus_arbiter
    import slave_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        bclk,
    input  logic        brst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  tsize_e      m0_tsize,
    input  ttype_e      m0_ttype,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_berror,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  tsize_e      m1_tsize,
    input  ttype_e      m1_ttype,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_berror,

    slave_bus_if.ic     ic
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("slave_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]        state;
    logic              last_sv;     // master served most recently
    logic              owner;       // master owning the current transfer
    logic [1:0]        req;
    mreq_t [1:0]       mreq;
    mreq_t             cur_q;
    logic              bstart_q;
    logic              ss_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic [1:0]        berr_q;
    logic [1:0][31:0]  rdata_q;

    logic              sel;
    logic              fin;
    logic              fin_err;
    logic [31:0]       fin_rdata;
    logic              to_hit;

    assign req     = {m1_req, m0_req};
    assign mreq[0] = '{addr: m0_addr, wdata: m0_wdata, tsize: m0_tsize, ttype: m0_ttype};
    assign mreq[1] = '{addr: m1_addr, wdata: m1_wdata, tsize: m1_tsize, ttype: m1_ttype};

    // Lone requester wins outright; on contention the master that was not
    // served last goes first.
    always_comb begin
        sel = last_sv;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_sv;
            default: sel = last_sv;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // to_cnt holds the number of WAIT cycles already completed, so this fires
    // in the WAIT cycle that brings the count to TIMEOUT_CYCLES.
    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge bclk) begin
        if (brst)
            to_cnt <= '0;
        else if (state == S_START)
            to_cnt <= '0;
        else if (state == S_WAIT)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Completion this cycle: bdone during START/WAIT, or a timeout in WAIT.
    // bdone takes precedence over a simultaneous timeout.
    always_comb begin
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        if (state == S_START || state == S_WAIT) begin
            if (ic.bdone) begin
                fin       = 1'b1;
                fin_err   = ic.berror;
                fin_rdata = ic.rdata;
            end else if (state == S_WAIT && to_hit) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
        end
    end

    always_ff @(posedge bclk) begin
        if (brst) begin
            state    <= S_IDLE;
            last_sv  <= 1'b1;
            owner    <= 1'b0;
            cur_q    <= '{addr: '0, wdata: '0, tsize: tsize_e'(0), ttype: ttype_e'(0)};
            bstart_q <= 1'b0;
            ss_q     <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            berr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            // done/rdata/berror are single-cycle and zero otherwise
            done_q  <= '0;
            berr_q  <= '0;
            rdata_q <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner    <= sel;
                        cur_q    <= mreq[sel];
                        bstart_q <= 1'b1;
                        ss_q     <= 1'b1;
                        gnt_q    <= sel ? 2'b10 : 2'b01;
                        state    <= S_START;
                    end
                end
                S_START, S_WAIT: begin
                    bstart_q <= 1'b0;
                    if (fin) begin
                        ss_q           <= 1'b0;
                        done_q[owner]  <= 1'b1;
                        berr_q[owner]  <= fin_err;
                        rdata_q[owner] <= fin_rdata;
                        state          <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    gnt_q   <= '0;
                    last_sv <= owner;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ic.addr   = cur_q.addr;
    assign ic.wdata  = cur_q.wdata;
    assign ic.tsize  = cur_q.tsize;
    assign ic.ttype  = cur_q.ttype;
    assign ic.bstart = bstart_q;
    assign ic.ss     = ss_q;

    assign m0_gnt    = gnt_q[0];
    assign m0_done   = done_q[0];
    assign m0_rdata  = rdata_q[0];
    assign m0_berror = berr_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m1_done   = done_q[1];
    assign m1_rdata  = rdata_q[1];
    assign m1_berror = berr_q[1];

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slave_bus_arbiter
//   Cycle-stepped bench. A transaction-level reference model schedules each
//   transfer as a start cycle plus slave latency and derives every expected
//   output from that timeline. Masters and the slave are driven from the model's
//   schedule, so a DUT timing error shows up as a miscompare.
// -----------------------------------------------------------------------------
module tb_slave_bus_arbiter;
    import slave_bus_pkg::*;

    localparam int TO = 8;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    logic        brst;
    logic        req_i   [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    tsize_e      tsize_i [2];
    ttype_e      ttype_i [2];
    logic        gnt_o   [2];
    logic        done_o  [2];
    logic        berr_o  [2];
    logic [31:0] rdata_o [2];

    slave_bus_if bus();

    slave_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .bclk(bclk), .brst(brst),
        .m0_req(req_i[0]), .m0_addr(addr_i[0]), .m0_wdata(wdata_i[0]),
        .m0_tsize(tsize_i[0]), .m0_ttype(ttype_i[0]),
        .m0_gnt(gnt_o[0]), .m0_done(done_o[0]), .m0_rdata(rdata_o[0]), .m0_berror(berr_o[0]),
        .m1_req(req_i[1]), .m1_addr(addr_i[1]), .m1_wdata(wdata_i[1]),
        .m1_tsize(tsize_i[1]), .m1_ttype(ttype_i[1]),
        .m1_gnt(gnt_o[1]), .m1_done(done_o[1]), .m1_rdata(rdata_o[1]), .m1_berror(berr_o[1]),
        .ic(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model: one transfer = start cycle t0 + slave latency lat
    bit          act = 0;
    int          t0 = 0, lat = 0;
    bit          own = 0, lastsv = 1;
    bit          no_resp = 0;
    logic [31:0] rsp_data = '0;
    bit          rsp_err = 0;
    logic [31:0] la_addr = '0, la_wdata = '0;
    logic [1:0]  la_tsize = '0;
    logic        la_ttype = 1'b0;

    // stimulus controls
    bit          auto_m [2];
    bit          stream [2];
    bit          noise_en = 0;
    int          force_lat = -1;       // -1 random, -2 slave never answers
    bit          force_data_en = 0;
    logic [31:0] force_data = '0;
    int          force_err = -1;

    // observations for directed checks
    int          bs_cnt, ss_cnt, m1_act, done0_cnt, done1_cnt;
    logic [31:0] got_rd0;
    logic        got_err0, got_err1;
    bit          prev_g [2];
    int          gq[$];
    int          bs_t[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr_stats();
        bs_cnt = 0; ss_cnt = 0; m1_act = 0; done0_cnt = 0; done1_cnt = 0;
        got_rd0 = '0; got_err0 = 1'b0; got_err1 = 1'b0;
        gq.delete(); bs_t.delete();
    endtask

    task automatic new_fields(input int i);
        addr_i[i]  = $urandom;
        wdata_i[i] = $urandom;
        tsize_i[i] = tsize_e'(2'($urandom_range(0, 2)));
        ttype_i[i] = ttype_e'(1'($urandom_range(0, 1)));
    endtask

    task automatic tick();
        bit          rs, free;
        bit          s_req [2];
        logic [31:0] s_addr [2], s_wdata [2];
        logic [1:0]  s_tsize [2];
        logic        s_ttype [2];
        bit          e_bs, e_ss;
        bit [1:0]    e_gnt, e_done, e_err;
        logic [31:0] e_rd [2];

        // inputs as the DUT samples them at the coming edge
        rs = brst;
        for (int i = 0; i < 2; i++) begin
            s_req[i] = req_i[i]; s_addr[i] = addr_i[i]; s_wdata[i] = wdata_i[i];
            s_tsize[i] = tsize_i[i]; s_ttype[i] = ttype_i[i];
        end
        @(posedge bclk); #1;

        // edge: reset, or arbitration if the bus was idle in the cycle just ended
        free = !act || (cyc >= t0 + lat + 2);
        if (rs) begin
            act = 0; lastsv = 1;
            la_addr = '0; la_wdata = '0; la_tsize = '0; la_ttype = 1'b0;
        end else if (free && (s_req[0] || s_req[1])) begin
            if (s_req[0] && s_req[1]) own = ~lastsv;
            else                      own = s_req[1];
            t0 = cyc + 1; act = 1;
            la_addr = s_addr[own]; la_wdata = s_wdata[own];
            la_tsize = s_tsize[own]; la_ttype = s_ttype[own];
            if (force_lat == -2) begin
                no_resp = 1; lat = TO; rsp_data = '0; rsp_err = 1;
            end else begin
                no_resp  = 0;
                lat      = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                rsp_data = force_data_en ? force_data : $urandom;
                rsp_err  = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 3) == 0);
            end
        end
        cyc++;

        // expected outputs for this cycle from the transfer timeline
        e_bs = 0; e_ss = 0; e_gnt = '0; e_done = '0; e_err = '0;
        e_rd[0] = '0; e_rd[1] = '0;
        if (act) begin
            e_bs = (cyc == t0);
            e_ss = (cyc >= t0) && (cyc <= t0 + lat);
            if (cyc >= t0 && cyc <= t0 + lat + 1) e_gnt[own] = 1'b1;
            if (cyc == t0 + lat + 1) begin
                e_done[own] = 1'b1; e_err[own] = rsp_err; e_rd[own] = rsp_data;
                lastsv = own;
            end
        end
        chk("ctrl{bstart,ss,gnt1,gnt0,done1,done0,berr1,berr0}",
            72'({bus.bstart, bus.ss, gnt_o[1], gnt_o[0], done_o[1], done_o[0], berr_o[1], berr_o[0]}),
            72'({e_bs, e_ss, e_gnt, e_done, e_err}));
        chk("m0_rdata", 72'(rdata_o[0]), 72'(e_rd[0]));
        chk("m1_rdata", 72'(rdata_o[1]), 72'(e_rd[1]));
        if (e_ss || rs)
            chk("ic_req{addr,wdata,tsize,ttype}",
                72'({bus.addr, bus.wdata, bus.tsize, bus.ttype}),
                72'({la_addr, la_wdata, la_tsize, la_ttype}));

        // observations
        if (bus.bstart) begin bs_cnt++; bs_t.push_back(cyc); end
        if (bus.ss) ss_cnt++;
        if (gnt_o[1] || done_o[1] || berr_o[1] || rdata_o[1] != 0) m1_act++;
        if (done_o[0]) begin done0_cnt++; got_rd0 = rdata_o[0]; got_err0 = berr_o[0]; end
        if (done_o[1]) begin done1_cnt++; got_err1 = berr_o[1]; end
        for (int i = 0; i < 2; i++) begin
            if (gnt_o[i] && !prev_g[i]) gq.push_back(i);
            prev_g[i] = gnt_o[i];
        end

        // masters: drop req the cycle after done; stream re-raises one cycle later
        for (int i = 0; i < 2; i++) begin
            if (act && own == i[0] && cyc == t0 + lat + 2) begin
                req_i[i] = 1'b0;
            end else if (!req_i[i] && (stream[i] || (auto_m[i] && $urandom_range(0, 3) == 0))) begin
                req_i[i] = 1'b1;
                new_fields(i);
            end
        end

        // slave: answer at t0+lat, quiet while in flight, optional junk otherwise
        if (act && !no_resp && cyc == t0 + lat) begin
            bus.bdone = 1'b1; bus.rdata = rsp_data; bus.berror = rsp_err;
        end else if (act && cyc >= t0 && cyc <= t0 + lat) begin
            bus.bdone = 1'b0; bus.rdata = $urandom; bus.berror = 1'($urandom_range(0, 1));
        end else begin
            bus.bdone  = noise_en && ($urandom_range(0, 2) == 0);
            bus.rdata  = $urandom;
            bus.berror = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic force_off();
        force_lat = -1; force_data_en = 0; force_err = -1;
    endtask

    initial begin
        brst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0;
            tsize_i[i] = TSIZE_BYTE; ttype_i[i] = TTYPE_READ;
            auto_m[i] = 0; stream[i] = 0; prev_g[i] = 0;
        end
        bus.bdone = 1'b0; bus.rdata = '0; bus.berror = 1'b0;
        clr_stats();

        // reset state
        tick(); tick();
        brst = 1'b0;
        tick();

        // single m0 read, slave answers 2 cycles after bstart
        clr_stats();
        force_lat = 2; force_data_en = 1; force_data = 32'hDEAD_BEEF; force_err = 0;
        req_i[0] = 1'b1; addr_i[0] = 32'h1000_0004; wdata_i[0] = 32'h0;
        tsize_i[0] = TSIZE_WORD; ttype_i[0] = TTYPE_READ;
        repeat (8) tick();
        chk("t1_bstart_cycles", 72'(bs_cnt), 72'(1));
        chk("t1_ss_cycles", 72'(ss_cnt), 72'(3));
        chk("t1_m0_done_cnt", 72'(done0_cnt), 72'(1));
        chk("t1_m0_rdata", 72'(got_rd0), 72'(32'hDEAD_BEEF));
        chk("t1_m1_quiet", 72'(m1_act), 72'(0));
        force_off();

        // contention straight after reset, twice: m0 then m1 each time
        brst = 1'b1; tick(); brst = 1'b0;
        force_lat = 1;
        for (int rep = 0; rep < 2; rep++) begin
            clr_stats();
            req_i[0] = 1'b1; new_fields(0);
            req_i[1] = 1'b1; new_fields(1);
            repeat (14) tick();
            chk("t2_grants", 72'(gq.size()), 72'(2));
            if (gq.size() == 2) begin
                chk("t2_first_m0", 72'(gq[0]), 72'(0));
                chk("t2_second_m1", 72'(gq[1]), 72'(1));
            end
        end

        // zero-wait slave with m0 streaming: START, RESP, IDLE(drop), IDLE(re-raise)
        clr_stats();
        force_lat = 0;
        stream[0] = 1;
        repeat (14) tick();
        stream[0] = 0;
        repeat (6) tick();
        chk("t3_starts", 72'(bs_cnt), 72'(4));
        if (bs_t.size() >= 3) begin
            chk("t3_period_a", 72'(bs_t[1] - bs_t[0]), 72'(4));
            chk("t3_period_b", 72'(bs_t[2] - bs_t[1]), 72'(4));
        end
        force_off();

        // m1 write with slave error, then a clean transfer
        clr_stats();
        force_lat = 1; force_err = 1;
        req_i[1] = 1'b1; addr_i[1] = 32'h4000_0010; wdata_i[1] = 32'h1234_5678;
        tsize_i[1] = TSIZE_WORD; ttype_i[1] = TTYPE_WRITE;
        repeat (8) tick();
        chk("t4_err_done", 72'(done1_cnt), 72'(1));
        chk("t4_err_flag", 72'(got_err1), 72'(1));
        force_err = 0; clr_stats();
        req_i[1] = 1'b1; addr_i[1] = 32'h4000_0014; ttype_i[1] = TTYPE_WRITE;
        repeat (8) tick();
        chk("t4_next_done", 72'(done1_cnt), 72'(1));
        chk("t4_next_clean", 72'(got_err1), 72'(0));
        force_off();

`ifdef ARB_TIMEOUT_EN
        // slave never answers an m0 transfer; m1 pending behind it
        clr_stats();
        force_lat = -2;
        req_i[0] = 1'b1; new_fields(0);
        tick(); tick();
        force_lat = 1;
        req_i[1] = 1'b1; new_fields(1);
        repeat (20) tick();
        chk("t5_to_done", 72'(done0_cnt), 72'(1));
        chk("t5_to_berror", 72'(got_err0), 72'(1));
        chk("t5_to_rdata", 72'(got_rd0), 72'(0));
        if (gq.size() == 2) chk("t5_m1_next", 72'(gq[1]), 72'(1));
        else chk("t5_grant_count", 72'(gq.size()), 72'(2));
        force_off();
`endif

        // randomized traffic with bdone noise outside transfers
        noise_en = 1;
        auto_m[0] = 1; auto_m[1] = 1;
        repeat (600) tick();
        auto_m[0] = 0; auto_m[1] = 0;
        repeat (30) tick();
        noise_en = 0;

        // reset during WAIT of an m1 transfer
        clr_stats();
        force_lat = 3;
        req_i[1] = 1'b1; new_fields(1);
        tick(); tick();
        chk("t7_m1_in_wait", 72'({gnt_o[1], bus.ss, bus.bstart}), 72'(3'b110));
        brst = 1'b1; req_i[1] = 1'b0;
        tick();
        brst = 1'b0;
        repeat (5) tick();
        chk("t7_no_done", 72'(done1_cnt), 72'(0));
        force_off();
        clr_stats();
        req_i[0] = 1'b1; new_fields(0);
        req_i[1] = 1'b1; new_fields(1);
        repeat (16) tick();
        if (gq.size() >= 1) chk("t7_m0_first", 72'(gq[0]), 72'(0));
        else chk("t7_grant_seen", 72'(gq.size()), 72'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
